// File: rtl/raster_pkg.sv
// Shared definitions for the raster stage: screen defaults, sequencer states,
// and the coordinate clamp used by the bounding-box logic.
package raster_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int EVAL_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  // Saturate a signed coordinate into the legal pixel range [0, limit].
  function automatic logic [EVAL_BITS-1:0] clamp(input int value, input int limit);
    logic [EVAL_BITS-1:0] r;
    if (value < 0) r = '0;
    else if (value > limit) r = limit[EVAL_BITS-1:0];
    else r = value[EVAL_BITS-1:0];
    return r;
  endfunction

endpackage

// File: rtl/bbox_clip.sv
// Combinational screen-clipped bounding box of three signed vertices, with
// detection of boxes that fall entirely off screen.
module bbox_clip
  import raster_pkg::*;
#(
  parameter int INT_BITS = 10,
  parameter int H_RES    = H_RES_DEF,
  parameter int V_RES    = V_RES_DEF
) (
  input  logic signed [INT_BITS:0] x_0,
  input  logic signed [INT_BITS:0] y_0,
  input  logic signed [INT_BITS:0] x_1,
  input  logic signed [INT_BITS:0] y_1,
  input  logic signed [INT_BITS:0] x_2,
  input  logic signed [INT_BITS:0] y_2,
  output logic [EVAL_BITS-1:0]     xmin,
  output logic [EVAL_BITS-1:0]     xmax,
  output logic [EVAL_BITS-1:0]     ymin,
  output logic [EVAL_BITS-1:0]     ymax,
  output logic                     empty
);

  localparam int CW = INT_BITS + 2;

  // One guard bit so the signed compares never overflow.
  logic signed [CW-1:0] xs0, xs1, xs2, ys0, ys1, ys2;
  logic signed [CW-1:0] xlo, xhi, ylo, yhi;

  assign xs0 = $signed({x_0[INT_BITS], x_0});
  assign xs1 = $signed({x_1[INT_BITS], x_1});
  assign xs2 = $signed({x_2[INT_BITS], x_2});
  assign ys0 = $signed({y_0[INT_BITS], y_0});
  assign ys1 = $signed({y_1[INT_BITS], y_1});
  assign ys2 = $signed({y_2[INT_BITS], y_2});

  always_comb begin
    xlo = xs0;
    xhi = xs0;
    ylo = ys0;
    yhi = ys0;
    if (xs1 < xlo) xlo = xs1;
    if (xs2 < xlo) xlo = xs2;
    if (xs1 > xhi) xhi = xs1;
    if (xs2 > xhi) xhi = xs2;
    if (ys1 < ylo) ylo = ys1;
    if (ys2 < ylo) ylo = ys2;
    if (ys1 > yhi) yhi = ys1;
    if (ys2 > yhi) yhi = ys2;
  end

  assign empty = (int'(xhi) < 0) || (int'(xlo) >= H_RES) ||
                 (int'(yhi) < 0) || (int'(ylo) >= V_RES);

  assign xmin = clamp(int'(xlo), H_RES - 1);
  assign xmax = clamp(int'(xhi), H_RES - 1);
  assign ymin = clamp(int'(ylo), V_RES - 1);
  assign ymax = clamp(int'(yhi), V_RES - 1);

endmodule

// File: rtl/raster_scan_ctrl.sv
// Triangle scan sequencer: accepts one triangle, walks its clipped bounding box
// in raster order through the external evaluator, and emits covered fragments.
module raster_scan_ctrl
  import raster_pkg::*;
#(
  parameter int evalBits    = EVAL_BITS,
  parameter int intBits     = 10,
  parameter int decimalBits = 3,
  parameter int H_RES       = H_RES_DEF,
  parameter int V_RES       = V_RES_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  // Both streams use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid holds its payload until then.
  input  logic                               tri_valid,
  output logic                               tri_ready,
  input  logic signed [intBits:0]            x_0,
  input  logic signed [intBits:0]            y_0,
  input  logic signed [intBits:0]            x_1,
  input  logic signed [intBits:0]            y_1,
  input  logic signed [intBits:0]            x_2,
  input  logic signed [intBits:0]            y_2,
  output logic signed [intBits:0]            vx_0,
  output logic signed [intBits:0]            vy_0,
  output logic signed [intBits:0]            vx_1,
  output logic signed [intBits:0]            vy_1,
  output logic signed [intBits:0]            vx_2,
  output logic signed [intBits:0]            vy_2,
  output logic [evalBits-1:0]                eval_x,
  output logic [evalBits-1:0]                eval_y,
  input  logic [intBits+decimalBits:0]       lambda_0,
  input  logic [intBits+decimalBits:0]       lambda_1,
  input  logic [intBits+decimalBits:0]       lambda_2,
  input  logic                               in_tris,
  output logic                               frag_valid,
  input  logic                               frag_ready,
  output logic [evalBits-1:0]                frag_x,
  output logic [evalBits-1:0]                frag_y,
  output logic [intBits+decimalBits:0]       frag_l0,
  output logic [intBits+decimalBits:0]       frag_l1,
  output logic [intBits+decimalBits:0]       frag_l2,
  output logic                               busy,
  output logic                               tri_done
);

  state_t              state;
  logic [evalBits-1:0] xmin, xmax, ymin, ymax;
  logic                empty;
  logic                consume;

  // Box is derived from the latched vertices, so it stays stable for the whole scan.
  bbox_clip #(
    .INT_BITS (intBits),
    .H_RES    (H_RES),
    .V_RES    (V_RES)
  ) u_bbox (
    .x_0   (vx_0),
    .y_0   (vy_0),
    .x_1   (vx_1),
    .y_1   (vy_1),
    .x_2   (vx_2),
    .y_2   (vy_2),
    .xmin  (xmin),
    .xmax  (xmax),
    .ymin  (ymin),
    .ymax  (ymax),
    .empty (empty)
  );

  assign consume = !frag_valid || frag_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tri_ready  <= 1'b1;
      busy       <= 1'b0;
      tri_done   <= 1'b0;
      frag_valid <= 1'b0;
      eval_x     <= '0;
      eval_y     <= '0;
      frag_x     <= '0;
      frag_y     <= '0;
      frag_l0    <= '0;
      frag_l1    <= '0;
      frag_l2    <= '0;
      vx_0       <= '0;
      vy_0       <= '0;
      vx_1       <= '0;
      vy_1       <= '0;
      vx_2       <= '0;
      vy_2       <= '0;
    end else begin
      tri_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tri_valid && tri_ready) begin
            vx_0      <= x_0;
            vy_0      <= y_0;
            vx_1      <= x_1;
            vy_1      <= y_1;
            vx_2      <= x_2;
            vy_2      <= y_2;
            tri_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (empty) begin
            tri_done <= 1'b1;
            state    <= DONE;
          end else begin
            eval_x <= xmin;
            eval_y <= ymin;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (consume) begin
            if (in_tris) begin
              frag_x     <= eval_x;
              frag_y     <= eval_y;
              frag_l0    <= lambda_0;
              frag_l1    <= lambda_1;
              frag_l2    <= lambda_2;
              frag_valid <= 1'b1;
            end else begin
              frag_valid <= 1'b0;
            end
            if (eval_x == xmax) begin
              eval_x <= xmin;
              eval_y <= eval_y + 1'b1;
            end else begin
              eval_x <= eval_x + 1'b1;
            end
            if (eval_x == xmax && eval_y == ymax) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (consume) begin
            frag_valid <= 1'b0;
            tri_done   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          tri_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Bench for raster_scan_ctrl: an edge-function evaluator model, per-cycle scan
// position checks, and a fragment scoreboard fed from a raster-order model.
module tb_raster_scan_ctrl;

  logic               clk;
  logic               rst_n;
  logic               tri_valid;
  logic               tri_ready;
  logic signed [10:0] x_0, y_0, x_1, y_1, x_2, y_2;
  logic signed [10:0] vx_0, vy_0, vx_1, vy_1, vx_2, vy_2;
  logic [9:0]         eval_x, eval_y;
  logic [13:0]        lambda_0, lambda_1, lambda_2;
  logic               in_tris;
  logic               frag_valid;
  logic               frag_ready;
  logic [9:0]         frag_x, frag_y;
  logic [13:0]        frag_l0, frag_l1, frag_l2;
  logic               busy;
  logic               tri_done;

  int n_vec = 0;
  int n_err = 0;
  logic [61:0] exp_q[$];
  int px_q[$];
  int py_q[$];
  int ev0, ev1, ev2;

  raster_scan_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tri_valid  (tri_valid),
    .tri_ready  (tri_ready),
    .x_0        (x_0),
    .y_0        (y_0),
    .x_1        (x_1),
    .y_1        (y_1),
    .x_2        (x_2),
    .y_2        (y_2),
    .vx_0       (vx_0),
    .vy_0       (vy_0),
    .vx_1       (vx_1),
    .vy_1       (vy_1),
    .vx_2       (vx_2),
    .vy_2       (vy_2),
    .eval_x     (eval_x),
    .eval_y     (eval_y),
    .lambda_0   (lambda_0),
    .lambda_1   (lambda_1),
    .lambda_2   (lambda_2),
    .in_tris    (in_tris),
    .frag_valid (frag_valid),
    .frag_ready (frag_ready),
    .frag_x     (frag_x),
    .frag_y     (frag_y),
    .frag_l0    (frag_l0),
    .frag_l1    (frag_l1),
    .frag_l2    (frag_l2),
    .busy       (busy),
    .tri_done   (tri_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int edge_fn(input int ax, input int ay, input int bx, input int by,
                                 input int px, input int py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  function automatic logic covered(input int a, input int b, input int c);
    return (a >= 0 && b >= 0 && c >= 0) || (a <= 0 && b <= 0 && c <= 0);
  endfunction

  function automatic logic [61:0] pack_frag(input int x, input int y, input int a,
                                            input int b, input int c);
    logic [9:0]  xs, ys;
    logic [13:0] as, bs, cs;
    xs = x[9:0];
    ys = y[9:0];
    as = a[13:0];
    bs = b[13:0];
    cs = c[13:0];
    return {xs, ys, as, bs, cs};
  endfunction

  function automatic int clampi(input int v, input int lim);
    if (v < 0) return 0;
    if (v > lim) return lim;
    return v;
  endfunction

  // Combinational evaluator, fed from the vertices the DUT presents.
  always_comb begin
    ev0 = edge_fn(int'(vx_1), int'(vy_1), int'(vx_2), int'(vy_2), int'(eval_x), int'(eval_y));
    ev1 = edge_fn(int'(vx_2), int'(vy_2), int'(vx_0), int'(vy_0), int'(eval_x), int'(eval_y));
    ev2 = edge_fn(int'(vx_0), int'(vy_0), int'(vx_1), int'(vy_1), int'(eval_x), int'(eval_y));
    in_tris  = covered(ev0, ev1, ev2);
    lambda_0 = ev0[13:0];
    lambda_1 = ev1[13:0];
    lambda_2 = ev2[13:0];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drives one triangle and follows it to tri_done. mode: 0 ready always,
  // 1 ready one cycle in three, 2 random ready. exp_k < 0 skips the latency check.
  task automatic run_tri(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int ax2, input int ay2, input int mode, input int exp_k);
    int xlo, xhi, ylo, yhi, cxlo, cxhi, cylo, cyhi;
    int npix, ptr, k;
    logic is_empty, done_seen;
    logic [61:0] e;
    logic [10:0] t0, t1, t2, t3, t4, t5;
    xlo = ax0; xhi = ax0; ylo = ay0; yhi = ay0;
    if (ax1 < xlo) xlo = ax1;
    if (ax2 < xlo) xlo = ax2;
    if (ax1 > xhi) xhi = ax1;
    if (ax2 > xhi) xhi = ax2;
    if (ay1 < ylo) ylo = ay1;
    if (ay2 < ylo) ylo = ay2;
    if (ay1 > yhi) yhi = ay1;
    if (ay2 > yhi) yhi = ay2;
    is_empty = (xhi < 0) || (xlo >= 640) || (yhi < 0) || (ylo >= 480);
    cxlo = clampi(xlo, 639); cxhi = clampi(xhi, 639);
    cylo = clampi(ylo, 479); cyhi = clampi(yhi, 479);
    px_q.delete();
    py_q.delete();
    exp_q.delete();
    if (!is_empty) begin
      for (int y = cylo; y <= cyhi; y++) begin
        for (int x = cxlo; x <= cxhi; x++) begin
          int a, b, c;
          px_q.push_back(x);
          py_q.push_back(y);
          a = edge_fn(ax1, ay1, ax2, ay2, x, y);
          b = edge_fn(ax2, ay2, ax0, ay0, x, y);
          c = edge_fn(ax0, ay0, ax1, ay1, x, y);
          if (covered(a, b, c)) exp_q.push_back(pack_frag(x, y, a, b, c));
        end
      end
    end
    npix = px_q.size();

    @(negedge clk);
    check("tri_ready_idle", tri_ready, 1);
    t0 = ax0[10:0]; t1 = ay0[10:0]; t2 = ax1[10:0];
    t3 = ay1[10:0]; t4 = ax2[10:0]; t5 = ay2[10:0];
    x_0 = t0; y_0 = t1; x_1 = t2; y_1 = t3; x_2 = t4; y_2 = t5;
    tri_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tri_valid = 1'b0;
    check("vtx_latch", {vx_0, vy_0, vx_1, vy_1, vx_2, vy_2}, {t0, t1, t2, t3, t4, t5});
    check("busy_setup", {busy, tri_ready}, 2'b10);
    // Inputs after acceptance must not matter.
    x_0 = 11'($urandom_range(0, 2047)); y_1 = 11'($urandom_range(0, 2047));
    x_2 = 11'($urandom_range(0, 2047));

    ptr = 0;
    done_seen = 1'b0;
    for (k = 0; k < 6000 && !done_seen; k++) begin
      if (k >= 1 && ptr < npix)
        check("eval_xy", {eval_x, eval_y}, {10'(px_q[ptr]), 10'(py_q[ptr])});
      case (mode)
        0:       frag_ready = 1'b1;
        1:       frag_ready = ((k % 3) == 0);
        default: frag_ready = 1'($urandom_range(0, 1));
      endcase
      if (k >= 1) tri_valid = 1'($urandom_range(0, 1));
      if (frag_valid && frag_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_frag", {frag_x, frag_y}, 20'hfffff);
        end else begin
          e = exp_q.pop_front();
          check("frag", {frag_x, frag_y, frag_l0, frag_l1, frag_l2}, e);
          check("frag_in_box", (int'(frag_x) >= cxlo && int'(frag_x) <= cxhi &&
                                int'(frag_y) >= cylo && int'(frag_y) <= cyhi), 1);
        end
      end
      if (k >= 1 && ptr < npix && (!frag_valid || frag_ready)) ptr++;
      if (tri_done) begin
        done_seen = 1'b1;
        if (exp_k >= 0) check("done_latency", k, exp_k);
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    tri_valid = 1'b0;
    check("done_seen", done_seen, 1);
    check("pixels_scanned", ptr, npix);
    check("frags_left", exp_q.size(), 0);
    @(posedge clk);
    @(negedge clk);
    check("after_done", {tri_done, tri_ready, busy, frag_valid}, 4'b0100);
  endtask

  initial begin
    rst_n = 1'b0;
    tri_valid = 1'b0;
    frag_ready = 1'b1;
    x_0 = '0; y_0 = '0; x_1 = '0; y_1 = '0; x_2 = '0; y_2 = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {tri_ready, frag_valid, busy, tri_done}, 4'b1000);
    check("rst_eval", {eval_x, eval_y, frag_x, frag_y}, 40'd0);
    check("rst_lambda", {frag_l0, frag_l1, frag_l2}, 42'd0);
    check("rst_vtx", {vx_0, vy_0, vx_1, vy_1, vx_2, vy_2}, 66'd0);
    rst_n = 1'b1;

    run_tri(10, 10, 20, 10, 10, 20, 0, 123);
    run_tri(10, 10, 20, 10, 10, 20, 1, -1);
    run_tri(-5, -5, 5, -5, -5, 5, 0, 38);
    run_tri(700, 10, 710, 10, 700, 20, 0, 1);
    run_tri(630, 470, 639, 470, 630, 479, 0, 102);
    run_tri(3, 7, 30, 2, 12, 25, 2, -1);

    // Abort mid-scan with a fragment held by back-pressure.
    @(negedge clk);
    x_0 = 11'sd10; y_0 = 11'sd10; x_1 = 11'sd20; y_1 = 11'sd10; x_2 = 11'sd10; y_2 = 11'sd20;
    tri_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tri_valid = 1'b0;
    frag_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_frag_valid", {frag_valid, busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {frag_valid, tri_ready, busy, tri_done}, 4'b0100);
    check("mid_rst_eval", {eval_x, eval_y}, 20'd0);
    @(negedge clk);
    rst_n = 1'b1;
    frag_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_rst", {tri_done, tri_ready}, 2'b01);
    end
    run_tri(10, 10, 20, 10, 10, 20, 0, 123);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
